// File: rtl/boot_rom_sequencer_if.sv
// Bus bundle between the boot ROM sequencer, the boot ROM and the core download port.
// The master side is the sequencer; the slave side is the surrounding system.
interface boot_rom_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              dn_go;
  logic              dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [DATA_W-1:0] dn_data;
  logic              dn_wait;
  logic [ADDR_W-1:0] execute_addr;
  logic              execute_enable;
  logic              done;

  modport master (
    input  start, abort, rom_data, dn_wait,
    output rom_addr, dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable, done
  );

  modport slave (
    output start, abort, rom_data, dn_wait,
    input  rom_addr, dn_go, dn_wr, dn_addr, dn_data, execute_addr, execute_enable, done
  );
endinterface

// File: rtl/boot_rom_sequencer.sv
// Copies a LENGTH-word boot image from ROM into the core download port, honouring
// dn_wait backpressure, then pulses execute_enable. All outputs are registered.
module boot_rom_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int LENGTH      = 276,
  parameter int DEST_BASE   = 0,
  parameter int EXEC_ADDR   = 0,
  parameter int ROM_LATENCY = 0,
  parameter int WR_HOLD     = 1,
  parameter int AUTO_START  = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  boot_rom_sequencer_if.master  bus
);

  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int FET_W = $clog2(ROM_LATENCY + 2);
  localparam int HLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);
  localparam logic [FET_W-1:0] FET_LAST = FET_W'(ROM_LATENCY);
  localparam logic [HLD_W-1:0] HLD_INIT = HLD_W'(WR_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WRITE = 3'd2,
    S_EXEC  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              auto_pend_q, auto_pend_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FET_W-1:0]  fet_q, fet_d;
  logic [HLD_W-1:0]  hld_q, hld_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
  logic [DATA_W-1:0] dn_data_q, dn_data_d;
  logic [ADDR_W-1:0] exec_addr_q, exec_addr_d;
  logic              dn_go_q, dn_go_d;
  logic              dn_wr_q, dn_wr_d;
  logic              exec_en_q, exec_en_d;
  logic              done_q, done_d;

  logic launch;
  logic fetch_last;
  logic wr_release;
  logic last_word;
  logic aborting;

  // abort outranks start, including the one-shot auto start after reset
  assign launch     = !bus.abort &&
                      (((state_q == S_IDLE) && (bus.start || auto_pend_q)) ||
                       ((state_q == S_DONE) && bus.start));
  assign aborting   = bus.abort && (state_q != S_IDLE);
  assign fetch_last = (fet_q == FET_LAST);
  assign wr_release = (state_q == S_WRITE) && !bus.dn_wait && (hld_q == '0);
  assign last_word  = (idx_q == LAST_IDX);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      auto_pend_q <= (AUTO_START != 0);
      idx_q       <= '0;
      fet_q       <= '0;
      hld_q       <= '0;
      rom_addr_q  <= '0;
      dn_addr_q   <= '0;
      dn_data_q   <= '0;
      exec_addr_q <= '0;
      dn_go_q     <= 1'b0;
      dn_wr_q     <= 1'b0;
      exec_en_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      auto_pend_q <= auto_pend_d;
      idx_q       <= idx_d;
      fet_q       <= fet_d;
      hld_q       <= hld_d;
      rom_addr_q  <= rom_addr_d;
      dn_addr_q   <= dn_addr_d;
      dn_data_q   <= dn_data_d;
      exec_addr_q <= exec_addr_d;
      dn_go_q     <= dn_go_d;
      dn_wr_q     <= dn_wr_d;
      exec_en_q   <= exec_en_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (launch) begin
      state_d = S_FETCH;
    end else if (aborting) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_FETCH: if (fetch_last) state_d = S_WRITE;
        S_WRITE: if (wr_release) state_d = last_word ? S_EXEC : S_FETCH;
        S_EXEC:  state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    auto_pend_d = 1'b0;
    idx_d       = idx_q;
    fet_d       = fet_q;
    hld_d       = hld_q;
    rom_addr_d  = rom_addr_q;
    dn_addr_d   = dn_addr_q;
    dn_data_d   = dn_data_q;
    exec_addr_d = exec_addr_q;
    dn_go_d     = dn_go_q;
    dn_wr_d     = dn_wr_q;
    exec_en_d   = exec_en_q;
    done_d      = done_q;

    if (launch) begin
      idx_d      = '0;
      fet_d      = '0;
      rom_addr_d = '0;
      dn_go_d    = 1'b1;
      done_d     = 1'b0;
    end else if (aborting) begin
      dn_go_d     = 1'b0;
      dn_wr_d     = 1'b0;
      exec_en_d   = 1'b0;
      exec_addr_d = '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // rom_addr has been stable since entering FETCH, so rom_data is valid now
          if (fetch_last) begin
            dn_data_d = bus.rom_data;
            dn_addr_d = ADDR_W'(DEST_BASE) + ADDR_W'(idx_q);
            dn_wr_d   = 1'b1;
            hld_d     = HLD_INIT;
          end else begin
            fet_d = fet_q + FET_W'(1);
          end
        end
        S_WRITE: begin
          if (wr_release) begin
            dn_wr_d = 1'b0;
            if (last_word) begin
              dn_go_d     = 1'b0;
              exec_en_d   = 1'b1;
              exec_addr_d = ADDR_W'(EXEC_ADDR);
            end else begin
              idx_d      = idx_q + IDX_W'(1);
              rom_addr_d = rom_addr_q + ADDR_W'(1);
              fet_d      = '0;
            end
          end else if (!bus.dn_wait && (hld_q != '0)) begin
            hld_d = hld_q - HLD_W'(1);
          end
        end
        S_EXEC: begin
          exec_en_d   = 1'b0;
          exec_addr_d = '0;
          done_d      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr       = rom_addr_q;
  assign bus.dn_go          = dn_go_q;
  assign bus.dn_wr          = dn_wr_q;
  assign bus.dn_addr        = dn_addr_q;
  assign bus.dn_data        = dn_data_q;
  assign bus.execute_addr   = exec_addr_q;
  assign bus.execute_enable = exec_en_q;
  assign bus.done           = done_q;

endmodule

// File: tb/tb_boot_rom_sequencer.sv
// Scoreboard bench for boot_rom_sequencer: two instances (default timing, and slow ROM
// with wrapping destination), expected write/busy/execute events queued per run.
module tb_boot_rom_sequencer;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic rst_a, rst_b;
  int   cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  boot_rom_sequencer_if #(.ADDR_W(16), .DATA_W(8)) ifa ();
  boot_rom_sequencer_if #(.ADDR_W(16), .DATA_W(8)) ifb ();

  boot_rom_sequencer #(.LENGTH(4)) dut_a (
    .clk_sys (clk_sys),
    .reset   (rst_a),
    .bus     (ifa)
  );

  boot_rom_sequencer #(
    .LENGTH(4), .DEST_BASE(16'hFFFE), .EXEC_ADDR(16'h1234),
    .ROM_LATENCY(2), .WR_HOLD(2), .AUTO_START(0)
  ) dut_b (
    .clk_sys (clk_sys),
    .reset   (rst_b),
    .bus     (ifb)
  );

  // ROM A: combinational, ROM[i] = A0+i.  ROM B: two register stages, ROM[i] = 50+i.
  assign ifa.rom_data = 8'hA0 + ifa.rom_addr[7:0];
  logic [7:0] rb1, rb2;
  always @(posedge clk_sys) begin
    rb1 <= 8'h50 + ifb.rom_addr[7:0];
    rb2 <= rb1;
  end
  assign ifb.rom_data = rb2;

  typedef struct packed {
    int cyc;
    int len;
    int addr;
    int data;
  } ev_t;

  // queue index = dut*3 + kind (0 write, 1 busy window, 2 execute)
  ev_t evq[6][$];
  int  n_chk  = 0;
  int  n_pass = 0;

  logic       prev_wr[2] = '{1'b0, 1'b0};
  logic       prev_go[2] = '{1'b0, 1'b0};
  logic       prev_ex[2] = '{1'b0, 1'b0};
  logic       wst[2]     = '{1'b0, 1'b0};
  int         ws[2]      = '{0, 0};
  int         gs[2]      = '{0, 0};
  logic [15:0] wa[2]     = '{16'h0, 16'h0};
  logic [7:0]  wd[2]     = '{8'h0, 8'h0};

  task automatic check_val(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
  endtask

  task automatic pop_cmp(int k, string nm, ev_t a);
    ev_t e;
    n_chk++;
    if (evq[k].size() == 0) begin
      $display("FAIL %s: unexpected event got cyc=%0d len=%0d addr=%0h data=%0h want none",
               nm, a.cyc, a.len, a.addr, a.data);
    end else begin
      e = evq[k].pop_front();
      if (a == e) n_pass++;
      else $display("FAIL %s: got cyc=%0d len=%0d addr=%0h data=%0h want cyc=%0d len=%0d addr=%0h data=%0h",
                    nm, a.cyc, a.len, a.addr, a.data, e.cyc, e.len, e.addr, e.data);
    end
  endtask

  task automatic mon(int d, logic go, logic wr, logic ex, logic dn,
                     logic [15:0] da, logic [7:0] dd, logic [15:0] ea);
    ev_t a;
    if (wr && !prev_wr[d]) begin
      ws[d] = cyc; wa[d] = da; wd[d] = dd; wst[d] = 1'b1;
    end else if (wr && prev_wr[d]) begin
      if (da != wa[d] || dd != wd[d]) wst[d] = 1'b0;
    end else if (!wr && prev_wr[d]) begin
      a.cyc = ws[d]; a.len = cyc - ws[d]; a.addr = int'(wa[d]);
      a.data = wst[d] ? int'(wd[d]) : -1;
      pop_cmp(d*3, (d == 0) ? "write_a" : "write_b", a);
    end
    if (go && !prev_go[d]) begin
      gs[d] = cyc;
      check_val((d == 0) ? "done_clear_a" : "done_clear_b", int'(dn), 0);
    end else if (!go && prev_go[d]) begin
      a.cyc = gs[d]; a.len = cyc - gs[d]; a.addr = 0; a.data = 0;
      pop_cmp(d*3+1, (d == 0) ? "busy_a" : "busy_b", a);
    end
    if (ex) begin
      a.cyc = cyc; a.len = int'(dn); a.addr = int'(ea); a.data = 0;
      pop_cmp(d*3+2, (d == 0) ? "exec_a" : "exec_b", a);
    end
    if (prev_ex[d])
      check_val((d == 0) ? "post_exec_a" : "post_exec_b", int'({ex, dn, ea}), int'({1'b0, 1'b1, 16'h0}));
    prev_wr[d] = wr;
    prev_go[d] = go;
    prev_ex[d] = ex;
  endtask

  always @(negedge clk_sys) begin
    mon(0, ifa.dn_go, ifa.dn_wr, ifa.execute_enable, ifa.done, ifa.dn_addr, ifa.dn_data, ifa.execute_addr);
    mon(1, ifb.dn_go, ifb.dn_wr, ifb.execute_enable, ifb.done, ifb.dn_addr, ifb.dn_data, ifb.execute_addr);
  end

  // t0 = cycle in which the start condition is sampled; stall_n extra cycles on word stall_idx
  task automatic push_run(int d, int t0, int n_wr, int rl, int wh, int base, int dbase,
                          int stall_idx, int stall_n, int go_len, int exec_addr);
    ev_t e;
    int  p;
    p = rl + 1 + wh;
    for (int i = 0; i < n_wr; i++) begin
      e.cyc  = t0 + 2 + rl + i*p + ((i > stall_idx && stall_idx >= 0) ? stall_n : 0);
      e.len  = wh + ((i == stall_idx) ? stall_n : 0);
      e.addr = (base + i) & 16'hFFFF;
      e.data = (dbase + i) & 8'hFF;
      evq[d*3].push_back(e);
    end
    e.cyc = t0 + 1; e.len = go_len; e.addr = 0; e.data = 0;
    evq[d*3+1].push_back(e);
    if (exec_addr >= 0) begin
      e.cyc = t0 + 1 + go_len; e.len = 0; e.addr = exec_addr; e.data = 0;
      evq[d*3+2].push_back(e);
    end
  endtask

  task automatic go_to(int c);
    while (cyc < c) @(negedge clk_sys);
  endtask

  task automatic pulse_start_a();
    ifa.start = 1'b1;
    @(negedge clk_sys);
    ifa.start = 1'b0;
  endtask

  int t0, t1;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.dn_wait = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.dn_wait = 1'b0;
    @(negedge clk_sys);
    go_to(3);
    check_val("reset_ctl_a", int'({ifa.dn_go, ifa.dn_wr, ifa.execute_enable, ifa.done}), 0);
    check_val("reset_bus_a", int'(ifa.rom_addr | ifa.dn_addr | ifa.execute_addr | {8'h0, ifa.dn_data}), 0);
    check_val("reset_ctl_b", int'({ifb.dn_go, ifb.dn_wr, ifb.execute_enable, ifb.done}), 0);

    // auto start after reset, four words, no backpressure
    t0 = cyc;
    push_run(0, t0, 4, 0, 1, 0, 'hA0, -1, 0, 8, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    go_to(t0 + 10);
    check_val("done_run1", int'(ifa.done), 1);
    go_to(t0 + 13);

    // start from DONE; extra start in FETCH ignored; dn_wait in FETCH ignored, then 3 stalls on word 1
    t0 = cyc;
    push_run(0, t0, 4, 0, 1, 0, 'hA0, 1, 3, 11, 0);
    ifa.start = 1'b1;
    go_to(t0 + 2);
    ifa.start = 1'b0;
    go_to(t0 + 3);
    ifa.dn_wait = 1'b1;
    go_to(t0 + 7);
    ifa.dn_wait = 1'b0;
    go_to(t0 + 16);

    // abort during the third write
    t0 = cyc;
    push_run(0, t0, 3, 0, 1, 0, 'hA0, -1, 0, 6, -1);
    pulse_start_a();
    go_to(t0 + 6);
    ifa.abort = 1'b1;
    go_to(t0 + 7);
    ifa.abort = 1'b0;
    go_to(t0 + 9);
    check_val("done_after_abort", int'({ifa.done, ifa.dn_go, ifa.execute_enable}), 0);
    go_to(t0 + 10);

    // restart from IDLE begins again at index 0
    t0 = cyc;
    push_run(0, t0, 4, 0, 1, 0, 'hA0, -1, 0, 8, 0);
    pulse_start_a();
    go_to(t0 + 13);

    // reset during word 1, auto restart once reset falls
    t0 = cyc;
    push_run(0, t0, 2, 0, 1, 0, 'hA0, -1, 0, 4, -1);
    pulse_start_a();
    go_to(t0 + 4);
    rst_a = 1'b1;
    go_to(t0 + 6);
    check_val("in_reset_ctl_a", int'({ifa.dn_go, ifa.dn_wr, ifa.execute_enable, ifa.done}), 0);
    check_val("in_reset_bus_a", int'(ifa.rom_addr | ifa.dn_addr | ifa.execute_addr | {8'h0, ifa.dn_data}), 0);
    go_to(t0 + 7);
    t1 = cyc;
    push_run(0, t1, 4, 0, 1, 0, 'hA0, -1, 0, 8, 0);
    rst_a = 1'b0;
    go_to(t1 + 13);

    // slow ROM, double-length writes, destination wrapping past FFFF
    t0 = cyc;
    push_run(1, t0, 4, 2, 2, 'hFFFE, 'h50, -1, 0, 20, 'h1234);
    ifb.start = 1'b1;
    go_to(t0 + 1);
    ifb.start = 1'b0;
    go_to(t0 + 24);

    for (int k = 0; k < 6; k++)
      check_val("leftover_events", evq[k].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
